auto_player: RTL and testbench

AUTO_PLAYER -- requirements
Module: auto_player

---
 rtl/whack_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 49 ++++
 rtl/auto_player.sv | 213 +++++++++++++++++++++
 tb/tb_auto_player.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the auto-player: FSM states, bus sizes and the
// active-low hex segment table the game uses to display digits.
// Segment bit order is {g,f,e,d,c,b,a}; a low line means the segment is lit.
package whack_pkg;

    localparam int unsigned NUM_SEGS = 7;
    localparam int unsigned NUM_BTNS = 8;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OBSERVE,
        ST_PRESS,
        ST_RELEASE,
        ST_DONE
    } state_e;

    // Entry [d] is the active-low pattern for hex digit d (listed F down to 0).
    localparam logic [15:0][NUM_SEGS-1:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [NUM_SEGS-1:0] hex_seg(input logic [3:0] digit);
        return HEX_SEG[digit];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decode of the game's active-low segment lines.
// Ports:
//   seg_i          active-low segment lines
//   onehot_valid_o exactly one line is low
//   idx_o          index of the low line (0 when not one-hot)
//   digit_valid_o  pattern matches one of the 16 hex glyphs
//   digit_o        decoded hex digit (0 when no match)
module seg7_decoder
    import whack_pkg::*;
(
    input  logic [NUM_SEGS-1:0] seg_i,
    output logic                onehot_valid_o,
    output logic [2:0]          idx_o,
    output logic                digit_valid_o,
    output logic [3:0]          digit_o
);

    logic [2:0] low_cnt;

    // Target index: count low lines and remember which one was low.
    always_comb begin
        low_cnt        = 3'd0;
        idx_o          = 3'd0;
        onehot_valid_o = 1'b0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (!seg_i[i]) begin
                low_cnt = low_cnt + 3'd1;
                idx_o   = 3'(i);
            end
        end
        onehot_valid_o = (low_cnt == 3'd1);
        if (!onehot_valid_o) begin
            idx_o = 3'd0;
        end
    end

    // Hex digit lookup against the display table.
    always_comb begin
        digit_valid_o = 1'b0;
        digit_o       = 4'd0;
        for (int d = 0; d < 16; d++) begin
            if (seg_i == hex_seg(4'(d))) begin
                digit_valid_o = 1'b1;
                digit_o       = 4'(d);
            end
        end
    end

endmodule

// File: rtl/auto_player.sv
// Autonomous player for a whack-a-mole style game: watches the segment
// display, presses the button matching a stable lit segment, and records
// the final score when the game signals game over.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        allow autonomous play
//   start_req     one-cycle request to press button 0 (start/restart)
//   miss_inject   one-cycle request to make the next target press wrong
//   seg_in        active-low segment lines from the game
//   dp_in         game decimal point, 0 = game over
//   score_in      game score bus
//   btn_out       registered button drive (at most one bit high)
//   busy          high while pressing or releasing
//   hits          correct target presses since the last start (saturating)
//   final_score   score captured at game over
//   score_valid   final_score / mismatch are valid
//   mismatch      displayed digit disagrees with score_in[3:0]
module auto_player
    import whack_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 6,
    parameter int unsigned GAP_CYCLES   = 6,
    parameter int unsigned REACT_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                start_req,
    input  logic                miss_inject,
    input  logic [NUM_SEGS-1:0] seg_in,
    input  logic                dp_in,
    input  logic [7:0]          score_in,
    output logic [NUM_BTNS-1:0] btn_out,
    output logic                busy,
    output logic [CNT_W-1:0]    hits,
    output logic [7:0]          final_score,
    output logic                score_valid,
    output logic                mismatch
);

    state_e                state_q, state_d;
    logic [NUM_BTNS-1:0]   btn_q, btn_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      hits_q, hits_d;
    logic [7:0]            final_q, final_d;
    logic                  valid_q, valid_d;
    logic                  mism_q, mism_d;
    logic                  pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      stable_q, stable_d;
    logic [NUM_SEGS-1:0]   seg_prev_q;

    logic                  onehot_valid;
    logic [2:0]            idx;
    logic                  digit_valid;
    logic [3:0]            digit;
    logic [2:0]            miss_idx;
    logic [CNT_W-1:0]      stable_next;
    logic                  start_press;
    logic                  target_press;

    seg7_decoder u_dec (
        .seg_i          (seg_in),
        .onehot_valid_o (onehot_valid),
        .idx_o          (idx),
        .digit_valid_o  (digit_valid),
        .digit_o        (digit)
    );

    // Deliberate miss lands on the neighbouring button, wrapping 7 -> 0.
    assign miss_idx = idx + 3'd1;

    // Stability count: restarts on an invalid or changed pattern, saturates.
    always_comb begin
        if (!onehot_valid || (seg_in != seg_prev_q)) begin
            stable_next = '0;
        end else if (stable_q == '1) begin
            stable_next = stable_q;
        end else begin
            stable_next = stable_q + CNT_W'(1);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        btn_d        = '0;
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        hits_d       = hits_q;
        final_d      = final_q;
        valid_d      = valid_q;
        mism_d       = mism_q;
        pend_d       = pend_q | miss_inject;
        start_press  = 1'b0;
        target_press = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    start_press = 1'b1;
                end else if (enable && dp_in) begin
                    state_d  = ST_OBSERVE;
                    stable_d = '0;
                end
            end
            ST_OBSERVE: begin
                stable_d = stable_next;
                if (start_req) begin
                    start_press = 1'b1;
                end else if (!dp_in) begin
                    // Game over wins over any press decided this cycle.
                    state_d = ST_DONE;
                    final_d = score_in;
                    valid_d = 1'b1;
                    mism_d  = !digit_valid || (digit != score_in[3:0]);
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (stable_next >= CNT_W'(REACT_CYCLES)) begin
                    target_press = 1'b1;
                end
            end
            ST_PRESS: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    btn_d = btn_q;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = enable ? ST_OBSERVE : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (start_req) begin
                    start_press = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_press) begin
            state_d = ST_PRESS;
            btn_d   = NUM_BTNS'(1);
            cnt_d   = '0;
            hits_d  = '0;
            valid_d = 1'b0;
            mism_d  = 1'b0;
        end

        if (target_press) begin
            state_d = ST_PRESS;
            cnt_d   = '0;
            if (pend_q) begin
                btn_d  = NUM_BTNS'(1) << miss_idx;
                pend_d = miss_inject;
            end else begin
                btn_d = NUM_BTNS'(1) << idx;
                if (hits_q != '1) begin
                    hits_d = hits_q + CNT_W'(1);
                end
            end
        end

        busy_d = (state_d == ST_PRESS) || (state_d == ST_RELEASE);
    end

    // State and registered outputs; reset drops the buttons immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            btn_q      <= '0;
            busy_q     <= 1'b0;
            hits_q     <= '0;
            final_q    <= '0;
            valid_q    <= 1'b0;
            mism_q     <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            stable_q   <= '0;
            seg_prev_q <= '1;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            busy_q     <= busy_d;
            hits_q     <= hits_d;
            final_q    <= final_d;
            valid_q    <= valid_d;
            mism_q     <= mism_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            seg_prev_q <= seg_in;
        end
    end

    assign btn_out     = btn_q;
    assign busy        = busy_q;
    assign hits        = hits_q;
    assign final_score = final_q;
    assign score_valid = valid_q;
    assign mismatch    = mism_q;

endmodule

// File: tb/tb_auto_player.sv
module tb_auto_player;
    import whack_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       start_req = 1'b0;
    logic       miss_inject = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       dp_in = 1'b1;
    logic [7:0] score_in = 8'h00;
    logic [7:0] btn_out;
    logic       busy;
    logic [7:0] hits;
    logic [7:0] final_score;
    logic       score_valid;
    logic       mismatch;

    int n_pass = 0;
    int n_total = 0;

    auto_player #(
        .HOLD_CYCLES  (6),
        .GAP_CYCLES   (6),
        .REACT_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start_req   (start_req),
        .miss_inject (miss_inject),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .score_in    (score_in),
        .btn_out     (btn_out),
        .busy        (busy),
        .hits        (hits),
        .final_score (final_score),
        .score_valid (score_valid),
        .mismatch    (mismatch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (btn_out !== 8'h00) $display("FAIL rst_btn: got %h want 00", btn_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (hits !== 8'h00) $display("FAIL rst_hits: got %0d want 0", hits); else n_pass++;
        n_total++; if (final_score !== 8'h00) $display("FAIL rst_final: got %h want 00", final_score); else n_pass++;
        n_total++; if (score_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", score_valid); else n_pass++;
        n_total++; if (mismatch !== 1'b0) $display("FAIL rst_mismatch: got %b want 0", mismatch); else n_pass++;
        n_total++; if (dut.state_q !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    endtask

    // Held target at index 2: first press 4 cycles after reset release.
    task automatic test_first_press();
        enable = 1'b1;
        dp_in  = 1'b1;
        seg_in = 7'b1111011;
        rst    = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_total++; if (btn_out !== 8'h00) $display("FAIL early_press c%0d: got %h want 00", c, btn_out); else n_pass++;
        end
        for (int c = 4; c <= 9; c++) begin
            tick();
            n_total++; if (btn_out !== 8'h04 || busy !== 1'b1) $display("FAIL hold c%0d: got btn %h busy %b want 04 1", c, btn_out, busy); else n_pass++;
        end
        n_total++; if (hits !== 8'd1) $display("FAIL hits_after_press: got %0d want 1", hits); else n_pass++;
        for (int c = 10; c <= 15; c++) begin
            tick();
            n_total++; if (btn_out !== 8'h00 || busy !== 1'b1) $display("FAIL gap c%0d: got btn %h busy %b want 00 1", c, btn_out, busy); else n_pass++;
        end
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL gap_end: got busy %b want 0", busy); else n_pass++;
    endtask

    // Play to hits=5, then restart from OBSERVE; a second start mid-press is ignored.
    task automatic test_start();
        int k;
        k = 0;
        while (!(hits == 8'd5 && busy == 1'b0) && k < 200) begin
            tick();
            k++;
        end
        n_total++; if (hits !== 8'd5 || busy !== 1'b0) $display("FAIL reach_hits5: got hits %0d busy %b want 5 0", hits, busy); else n_pass++;
        start_req = 1'b1;
        seg_in    = 7'h7F;
        tick();
        start_req = 1'b0;
        n_total++; if (hits !== 8'd0) $display("FAIL start_hits: got %0d want 0", hits); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_total++; if (btn_out !== 8'h01) $display("FAIL start_mask i%0d: got %h want 01", i, btn_out); else n_pass++;
            if (i == 1) start_req = 1'b1;
            if (i == 2) start_req = 1'b0;
        end
        tick();
        n_total++; if (btn_out !== 8'h00 || busy !== 1'b1) $display("FAIL start_len: got btn %h busy %b want 00 1", btn_out, busy); else n_pass++;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL start_release_timeout: got busy %b want 0", busy); else n_pass++;
    endtask

    // Two miss pulses collapse into one wrong press at index 7.
    task automatic test_miss();
        int k;
        miss_inject = 1'b1;
        tick();
        tick();
        miss_inject = 1'b0;
        seg_in = 7'b0111111;
        k = 0;
        while (btn_out == 8'h00 && k < 20) begin
            tick();
            k++;
        end
        n_total++; if (btn_out !== 8'h80) $display("FAIL miss_mask: got %h want 80", btn_out); else n_pass++;
        n_total++; if (hits !== 8'd0) $display("FAIL miss_hits: got %0d want 0", hits); else n_pass++;
        k = 0;
        while (btn_out != 8'h00 && k < 20) begin
            tick();
            k++;
        end
        k = 0;
        while (btn_out == 8'h00 && k < 30) begin
            tick();
            k++;
        end
        n_total++; if (btn_out !== 8'h40) $display("FAIL after_miss_mask: got %h want 40", btn_out); else n_pass++;
        n_total++; if (hits !== 8'd1) $display("FAIL after_miss_hits: got %0d want 1", hits); else n_pass++;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL miss_release_timeout: got busy %b want 0", busy); else n_pass++;
    endtask

    // Target changes every 2 cycles: never stable long enough to press.
    task automatic test_toggle();
        for (int i = 0; i < 40; i++) begin
            seg_in = ((i / 2) % 2 == 1) ? 7'b1111110 : 7'b1111011;
            tick();
            n_total++; if (btn_out !== 8'h00) $display("FAIL toggle i%0d: got %h want 00", i, btn_out); else n_pass++;
        end
        n_total++; if (hits !== 8'd1) $display("FAIL toggle_hits: got %0d want 1", hits); else n_pass++;
    endtask

    // Game over: capture score, compare with displayed digit; restart and retry with wrong score.
    task automatic test_done();
        int k;
        dp_in    = 1'b0;
        seg_in   = 7'b0010010;
        score_in = 8'h05;
        tick();
        n_total++; if (final_score !== 8'h05) $display("FAIL done_final: got %h want 05", final_score); else n_pass++;
        n_total++; if (score_valid !== 1'b1) $display("FAIL done_valid: got %b want 1", score_valid); else n_pass++;
        n_total++; if (mismatch !== 1'b0) $display("FAIL done_mismatch: got %b want 0", mismatch); else n_pass++;
        score_in = 8'h06;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (btn_out !== 8'h00 || final_score !== 8'h05 || score_valid !== 1'b1 || busy !== 1'b0)
                $display("FAIL done_hold i%0d: got btn %h final %h valid %b busy %b want 00 05 1 0", i, btn_out, final_score, score_valid, busy);
            else n_pass++;
        end
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        n_total++; if (btn_out !== 8'h01 || score_valid !== 1'b0 || mismatch !== 1'b0)
            $display("FAIL done_restart: got btn %h valid %b mism %b want 01 0 0", btn_out, score_valid, mismatch);
        else n_pass++;
        k = 0;
        while (!score_valid && k < 40) begin
            tick();
            k++;
        end
        n_total++; if (final_score !== 8'h06 || score_valid !== 1'b1) $display("FAIL done2_final: got %h valid %b want 06 1", final_score, score_valid); else n_pass++;
        n_total++; if (mismatch !== 1'b1) $display("FAIL done2_mismatch: got %b want 1", mismatch); else n_pass++;
    endtask

    // Reset in the third cycle of a target press drops the button without a clock edge.
    task automatic test_reset_mid_press();
        int k;
        dp_in     = 1'b1;
        seg_in    = 7'b1111011;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        k = 0;
        while (btn_out != 8'h04 && k < 60) begin
            tick();
            k++;
        end
        n_total++; if (btn_out !== 8'h04 || hits !== 8'd1) $display("FAIL pre_rst_press: got btn %h hits %0d want 04 1", btn_out, hits); else n_pass++;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        n_total++; if (btn_out !== 8'h00) $display("FAIL async_rst_btn: got %h want 00", btn_out); else n_pass++;
        n_total++; if (hits !== 8'd0 || busy !== 1'b0 || final_score !== 8'h00) $display("FAIL async_rst_regs: got hits %0d busy %b final %h want 0 0 00", hits, busy, final_score); else n_pass++;
        n_total++; if (dut.state_q !== ST_IDLE) $display("FAIL async_rst_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_start();
        test_miss();
        test_toggle();
        test_done();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
